hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline (PC -> F/D -> D/X -> X/M -> M/W latches).

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_ir_decode.sv | 37 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared decode constants, IR field summary and FSM encoding for the hazard sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Opcodes, ir[31:27]
  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_LW  = 5'b01000;

  // ALU sub-ops, ir[6:2], meaningful only when op == OP_ALU
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  // Hazard-relevant view of one instruction.
  typedef struct packed {
    logic       is_lw;
    logic       is_mul;
    logic       is_div;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       src_b_vld;
    logic [4:0] rd;
  } dec_t;

endpackage

// File: rtl/hazard_ctrl_ir_decode.sv
// Purpose: reduce a 32-bit IR to the fields the hazard logic needs (load/mul/div, sources, dest).
// Latency: purely combinational.
// Backpressure: none.
// Ports: ir (instruction word) -> dec (packed dec_t summary).
module ir_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [4:0] op;
  logic [4:0] aluop;
  logic       rd_is_src;
  logic       unused_ir_bits;

  assign op    = ir[31:27];
  assign aluop = ir[6:2];

  // Stores and the compare/jump-register forms read rd as their second operand.
  assign rd_is_src = (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);

  always_comb begin
    dec           = '0;
    dec.is_lw     = (op == OP_LW);
    dec.is_mul    = (op == OP_ALU) && (aluop == ALU_MUL);
    dec.is_div    = (op == OP_ALU) && (aluop == ALU_DIV);
    dec.src_a     = ir[21:17];
    dec.rd        = ir[26:22];
    dec.src_b_vld = (op == OP_ALU) || rd_is_src;
    dec.src_b     = (op == OP_ALU) ? ir[16:12] : ir[26:22];
  end

  // shamt and the two low bits never influence hazards.
  assign unused_ir_bits = ^{ir[11:7], ir[1:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline plus multdiv start/wait control.
// Latency: all enables/flushes/starts are combinational from state + inputs (0 cycles).
// Backpressure: freezes PC/F-D/D-X while multdiv busy (bounded by MD_TIMEOUT); 1 bubble on load-use.
// Ports: clock, clear_n (async active-low); fd_ir/dx_ir, branch_taken, md_ready, md_exception in;
//        pc_en, pc_sel_target, fd/dx/xm/mw_en, fd/dx/xm_flush, ctrl_mult, ctrl_div, md_timeout out.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        pc_sel_target,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_flush,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_timeout
);

  localparam int CW = $clog2(MD_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   md_cnt_q, md_cnt_d;
  logic            md_timeout_q;
  logic            timeout_set;

  dec_t            fd_dec, dx_dec;
  logic            load_use;
  logic            md_start;
  logic            md_expire;

  // Pre-reset-gating versions of every control output.
  logic pc_en_c, pc_sel_c, fd_en_c, dx_en_c, xm_en_c, mw_en_c;
  logic fd_flush_c, dx_flush_c, xm_flush_c, ctrl_mult_c, ctrl_div_c;

  logic unused_md_exception;

  ir_decode u_fd_dec (.ir(fd_ir), .dec(fd_dec));
  ir_decode u_dx_dec (.ir(dx_ir), .dec(dx_dec));

  // $0 is hardwired, so a load targeting it can never feed a consumer.
  assign load_use = dx_dec.is_lw && (dx_dec.rd != 5'd0) &&
                    ((fd_dec.src_a == dx_dec.rd) ||
                     (fd_dec.src_b_vld && (fd_dec.src_b == dx_dec.rd)));

  assign md_start  = dx_dec.is_mul || dx_dec.is_div;
  assign md_expire = (md_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    timeout_set = 1'b0;
    pc_en_c     = 1'b1;
    pc_sel_c    = 1'b0;
    fd_en_c     = 1'b1;
    dx_en_c     = 1'b1;
    xm_en_c     = 1'b1;
    mw_en_c     = 1'b1;
    fd_flush_c  = 1'b0;
    dx_flush_c  = 1'b0;
    xm_flush_c  = 1'b0;
    ctrl_mult_c = 1'b0;
    ctrl_div_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (md_start) begin
          // Start pulse only exists on this edge; the op stays parked in D/X while X/M gets bubbles.
          ctrl_mult_c = dx_dec.is_mul;
          ctrl_div_c  = dx_dec.is_div;
          pc_en_c     = 1'b0;
          fd_en_c     = 1'b0;
          dx_en_c     = 1'b0;
          xm_flush_c  = 1'b1;
          md_cnt_d    = '0;
          state_d     = ST_MD_WAIT;
        end else if (branch_taken) begin
          // Squashing the wrong-path pair makes any load-use between them moot.
          pc_sel_c   = 1'b1;
          fd_flush_c = 1'b1;
          dx_flush_c = 1'b1;
        end else if (load_use) begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          dx_flush_c = 1'b1;
        end
      end

      ST_MD_WAIT: begin
        if (md_ready) begin
          // Result lands in X/M this edge; ready beats a simultaneous timeout.
          md_cnt_d = '0;
          state_d  = ST_RUN;
        end else begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          dx_en_c    = 1'b0;
          xm_flush_c = 1'b1;
          if (md_expire) begin
            // Abandon the op: drop it from D/X so it is not restarted.
            timeout_set = 1'b1;
            dx_flush_c  = 1'b1;
            md_cnt_d    = '0;
            state_d     = ST_RUN;
          end else begin
            md_cnt_d = md_cnt_q + CW'(1);
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= ST_RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (timeout_set) md_timeout_q <= 1'b1;
    end
  end

  // Outputs are held quiet for as long as reset is asserted, not just after the next edge.
  assign pc_en         = clear_n & pc_en_c;
  assign pc_sel_target = clear_n & pc_sel_c;
  assign fd_en         = clear_n & fd_en_c;
  assign dx_en         = clear_n & dx_en_c;
  assign xm_en         = clear_n & xm_en_c;
  assign mw_en         = clear_n & mw_en_c;
  assign fd_flush      = clear_n & fd_flush_c;
  assign dx_flush      = clear_n & dx_flush_c;
  assign xm_flush      = clear_n & xm_flush_c;
  assign ctrl_mult     = clear_n & ctrl_mult_c;
  assign ctrl_div      = clear_n & ctrl_div_c;
  assign md_timeout    = md_timeout_q;

  // Exception is consumed by the datapath alongside the result; sequencing is unaffected.
  assign unused_md_exception = md_exception;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed + randomized self-checking bench for hazard_ctrl against a rule-level model.
// Latency: checks combinational outputs 1ns after inputs change (between edges).
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int MDT = 8;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] fd_ir = '0;
  logic [31:0] dx_ir = '0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        pc_en, pc_sel_target, fd_en, dx_en, xm_en, mw_en;
  logic        fd_flush, dx_flush, xm_flush, ctrl_mult, ctrl_div, md_timeout;

  int checks = 0;
  int errors = 0;

  // Model: is the multdiv busy, wait cycles remaining before abort, sticky timeout.
  bit m_busy = 1'b0;
  int m_left = 0;
  bit m_to   = 1'b0;

  hazard_ctrl #(.MD_TIMEOUT(MDT)) dut (
    .clock(clock), .clear_n(clear_n), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .pc_en(pc_en), .pc_sel_target(pc_sel_target), .fd_en(fd_en), .dx_en(dx_en),
    .xm_en(xm_en), .mw_en(mw_en), .fd_flush(fd_flush), .dx_flush(dx_flush),
    .xm_flush(xm_flush), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(int op, int rd, int rs, int rt, int aluop);
    logic [4:0] o, d, s, t, a;
    o = op[4:0]; d = rd[4:0]; s = rs[4:0]; t = rt[4:0]; a = aluop[4:0];
    return {o, d, s, t, 5'd0, a, 2'b00};
  endfunction

  // Does instruction ir read register r as an operand?
  function automatic bit reads(logic [31:0] ir, logic [4:0] r);
    logic [4:0] op;
    op = ir[31:27];
    if (ir[21:17] == r) return 1'b1;
    if (op == 5'd0) return ir[16:12] == r;
    if (op == 5'd7 || op == 5'd2 || op == 5'd6 || op == 5'd4) return ir[26:22] == r;
    return 1'b0;
  endfunction

  function automatic bit is_mul(logic [31:0] ir);
    return ir[31:27] == 5'd0 && ir[6:2] == 5'd6;
  endfunction

  function automatic bit is_div(logic [31:0] ir);
    return ir[31:27] == 5'd0 && ir[6:2] == 5'd7;
  endfunction

  // {pc_en, pc_sel, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, mult, div}
  function automatic logic [10:0] vec(bit pc, bit sel, bit fd, bit dx, bit xm, bit mw,
                                      bit ff, bit df, bit xf, bit m, bit d);
    return {pc, sel, fd, dx, xm, mw, ff, df, xf, m, d};
  endfunction

  function automatic logic [10:0] expect_out();
    logic [4:0] lrd;
    if (!clear_n) return '0;
    if (!m_busy) begin
      if (is_mul(dx_ir) || is_div(dx_ir))
        return vec(0, 0, 0, 0, 1, 1, 0, 0, 1, is_mul(dx_ir), is_div(dx_ir));
      if (branch_taken) return vec(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      lrd = dx_ir[26:22];
      if (dx_ir[31:27] == 5'd8 && lrd != 5'd0 && reads(fd_ir, lrd))
        return vec(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
      return vec(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    end
    if (md_ready) return vec(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    if (m_left == 1) return vec(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    return vec(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
  endfunction

  function automatic logic [10:0] dut_vec();
    return {pc_en, pc_sel_target, fd_en, dx_en, xm_en, mw_en,
            fd_flush, dx_flush, xm_flush, ctrl_mult, ctrl_div};
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clock();
    if (!clear_n) return;
    if (!m_busy) begin
      if (is_mul(dx_ir) || is_div(dx_ir)) begin
        m_busy = 1'b1;
        m_left = MDT;
      end
    end else if (md_ready) begin
      m_busy = 1'b0;
    end else if (m_left == 1) begin
      m_busy = 1'b0;
      m_to   = 1'b1;
    end else begin
      m_left--;
    end
  endtask

  // Inputs already driven just after a negedge; check, then advance one clock.
  task automatic step(string tag);
    #1;
    check(tag, 16'(dut_vec()), 16'(expect_out()));
    check({tag, "_to"}, 16'(md_timeout), 16'(m_to));
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  logic [31:0] lw3, add_r3, nop_ir, mul_ir, div_ir;

  initial begin
    lw3    = mk(8, 3, 1, 0, 0);
    add_r3 = mk(0, 4, 3, 5, 0);
    nop_ir = 32'h0;
    mul_ir = mk(0, 6, 1, 2, 6);
    div_ir = mk(0, 6, 1, 2, 7);

    // Reset: outputs held low even with a start-worthy op present.
    dx_ir = mul_ir;
    branch_taken = 1'b1;
    #12;
    check("reset_outs", 16'(dut_vec()), 16'h0);
    check("reset_to", 16'(md_timeout), 16'h0);
    @(negedge clock);
    clear_n = 1'b1;
    branch_taken = 1'b0;

    // Load-use: exactly one bubble.
    dx_ir = lw3; fd_ir = add_r3;
    #1;
    check("lu_pc_en", 16'(pc_en), 16'h0);
    step("lu_add");
    dx_ir = nop_ir;
    step("lu_after");

    // Load to $0 never stalls.
    dx_ir = mk(8, 0, 1, 0, 0); fd_ir = mk(0, 4, 0, 0, 0);
    step("lw_r0");

    // sw reads rd as its data source.
    dx_ir = lw3; fd_ir = mk(7, 3, 1, 0, 0);
    step("lu_sw");

    // Taken branch overrides load-use.
    fd_ir = add_r3; branch_taken = 1'b1;
    #1;
    check("br_sel", 16'(pc_sel_target), 16'h1);
    step("br_over_lu");
    branch_taken = 1'b0;

    // Multiply: start pulse, 4 frozen cycles, ready on the 5th.
    dx_ir = mul_ir; fd_ir = nop_ir;
    step("mul_start");
    for (int i = 0; i < 4; i++) step("mul_wait");
    md_ready = 1'b1;
    step("mul_done");
    md_ready = 1'b0; dx_ir = nop_ir;
    step("mul_resume");

    // Divide with no ready: abort after MDT wait cycles.
    dx_ir = div_ir;
    step("div_start");
    for (int i = 0; i < MDT; i++) step("div_wait");
    dx_ir = nop_ir;
    step("after_to");
    check("to_sticky", 16'(md_timeout), 16'h1);

    // Async reset in the middle of a wait.
    dx_ir = div_ir;
    step("div2_start");
    step("div2_wait");
    step("div2_wait");
    #2 clear_n = 1'b0;
    m_busy = 1'b0; m_to = 1'b0;
    #1;
    check("mid_rst_outs", 16'(dut_vec()), 16'h0);
    check("mid_rst_to", 16'(md_timeout), 16'h0);
    @(posedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    dx_ir = mul_ir;
    step("mul_after_rst");
    dx_ir = nop_ir;
    for (int i = 0; i < MDT - 1; i++) step("drain_wait");
    md_ready = 1'b1;
    step("ready_on_last");
    md_ready = 1'b0;
    check("ready_beats_to", 16'(md_timeout), 16'h0);

    // Random phase: small register pool to make collisions common.
    for (int n = 0; n < 600; n++) begin
      int ops[8] = '{0, 8, 7, 2, 6, 4, 1, 3};
      int op, aop;
      op = ops[$urandom_range(0, 7)];
      fd_ir = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 7));
      op = ops[$urandom_range(0, 7)];
      aop = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      dx_ir = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), aop);
      branch_taken = ($urandom_range(0, 3) == 0);
      md_ready     = ($urandom_range(0, 5) == 0);
      md_exception = md_ready & ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
